// File: rtl/palette_pkg.sv
// Shared constants and helpers for the palette converter.
// The base colour table is stored as 3-bit channel masks (bit CH_B/CH_G/CH_R);
// default_entry() expands a mask into a full-width reset value.
package palette_pkg;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam int NUM_BASE    = 8;
  // Widest entry default_entry() can build; callers slice the low bits.
  localparam int MAX_ENTRY_W = 1024;

  // Entry i: mask bit CH_x set means channel x is all-ones.
  // black, blue, green, cyan, red, magenta, yellow, white.
  localparam logic [NUM_BASE-1:0][2:0] DEFAULT_PALETTE = {
    3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000
  };

  // Reset value of palette entry idx; extra channels and entries >= 8 are zero.
  function automatic logic [MAX_ENTRY_W-1:0] default_entry(input int idx,
                                                          input int chan_w,
                                                          input int num_chan);
    logic [MAX_ENTRY_W-1:0] ones;
    logic [MAX_ENTRY_W-1:0] v;
    logic [2:0]             mask;
    v    = '0;
    mask = '0;
    ones = (MAX_ENTRY_W'(1) << chan_w) - MAX_ENTRY_W'(1);
    if (idx >= 0 && idx < NUM_BASE) begin
      mask = DEFAULT_PALETTE[idx[2:0]];
      if (mask[CH_B] && num_chan > CH_B) v = v | (ones << (CH_B * chan_w));
      if (mask[CH_G] && num_chan > CH_G) v = v | (ones << (CH_G * chan_w));
      if (mask[CH_R] && num_chan > CH_R) v = v | (ones << (CH_R * chan_w));
    end
    return v;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Register-based palette: async reset load of the default table, one write
// port, combinational read with write-through when the write hits the read index.
module palette_ram
  import palette_pkg::*;
#(
  parameter int INDEX_W  = 3,
  parameter int CHAN_W   = 8,
  parameter int NUM_CHAN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [INDEX_W-1:0]         wr_addr_i,
  input  logic [NUM_CHAN*CHAN_W-1:0] wr_data_i,
  input  logic [INDEX_W-1:0]         rd_addr_i,
  output logic [NUM_CHAN*CHAN_W-1:0] rd_data_o
);

  localparam int DEPTH  = 2 ** INDEX_W;
  localparam int DATA_W = NUM_CHAN * CHAN_W;

  logic [DATA_W-1:0] entry_w [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [MAX_ENTRY_W-1:0] RST_FULL = default_entry(gi, CHAN_W, NUM_CHAN);
      localparam logic [DATA_W-1:0]      RST_VAL  = RST_FULL[DATA_W-1:0];

      logic [DATA_W-1:0] entry_q;

      // One palette entry: restore default on reset, take write data on address hit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q <= RST_VAL;
        end else if (wr_en_i && wr_addr_i == INDEX_W'(gi)) begin
          entry_q <= wr_data_i;
        end
      end

      assign entry_w[gi] = entry_q;
    end
  endgenerate

  // Read mux; a same-cycle write to the read index is forwarded.
  always_comb begin
    rd_data_o = entry_w[rd_addr_i];
    if (wr_en_i && wr_addr_i == rd_addr_i) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/palette_converter.sv
// Colour-index to RGB lookup with valid/ready streaming and a writable palette.
// Optional macro PALETTE_BRIGHTNESS_EN adds a brightness input and a second
// pipeline stage that scales each channel by (brightness + 1) / 2**CHAN_W.
module palette_converter
  import palette_pkg::*;
#(
  parameter int INDEX_W  = 3,
  parameter int CHAN_W   = 8,
  parameter int NUM_CHAN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INDEX_W-1:0]         colour,
`ifdef PALETTE_BRIGHTNESS_EN
  input  logic [CHAN_W-1:0]          brightness,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CHAN*CHAN_W-1:0] rgb,
  input  logic                       wr_en,
  input  logic [INDEX_W-1:0]         wr_addr,
  input  logic [NUM_CHAN*CHAN_W-1:0] wr_data
);

  localparam int DATA_W = NUM_CHAN * CHAN_W;

  logic              adv;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;

  palette_ram #(
    .INDEX_W  (INDEX_W),
    .CHAN_W   (CHAN_W),
    .NUM_CHAN (NUM_CHAN)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (colour),
    .rd_data_o (rd_data)
  );

  // Only the output-stage stall gates acceptance; in_valid never feeds in_ready.
  assign adv       = enable & (~out_valid_q | out_ready);
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign rgb       = rgb_q;

`ifdef PALETTE_BRIGHTNESS_EN
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [CHAN_W-1:0] s1_bright_q, s1_bright_d;
  logic [DATA_W-1:0] scaled;

  generate
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_scale
      logic [2*CHAN_W:0] prod;
      logic              unused_prod_msb;
      // Full-width product; the >> CHAN_W result always fits in CHAN_W bits.
      assign prod = (2*CHAN_W+1)'(s1_data_q[gi*CHAN_W +: CHAN_W]) *
                    (2*CHAN_W+1)'({1'b0, s1_bright_q} + (CHAN_W+1)'(1));
      assign scaled[gi*CHAN_W +: CHAN_W] = prod[2*CHAN_W-1:CHAN_W];
      assign unused_prod_msb = prod[2*CHAN_W];
    end
  endgenerate

  // Next state: both stages move together on adv.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_bright_d = s1_bright_q;
    out_valid_d = out_valid_q;
    rgb_d       = rgb_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_data_d   = rd_data;
        s1_bright_d = brightness;
      end
      if (s1_valid_q) begin
        rgb_d = scaled;
      end
    end
  end

  // Stage-1 and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_bright_q <= '0;
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_bright_q <= s1_bright_d;
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
    end
  end
`else
  // Next state: load on accepted request, drop valid on an idle advance.
  always_comb begin
    out_valid_d = out_valid_q;
    rgb_d       = rgb_q;
    if (adv) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        rgb_d = rd_data;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
    end
  end
`endif

endmodule

// File: tb/tb_palette_converter.sv
// Directed bench for palette_converter: default 3/8/3 instance with a
// hand-filled expected palette and an output queue, plus a 4/4/3 instance.
module tb_palette_converter;

`ifdef PALETTE_BRIGHTNESS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  colour = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] rgb;

  logic        in_valid4 = 1'b0;
  logic        out_ready4 = 1'b1;
  logic [3:0]  colour4 = '0;
  logic        in_ready4;
  logic        out_valid4;
  logic [11:0] rgb4;

`ifdef PALETTE_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'hFF;
  logic [3:0]  brightness4 = 4'hF;
`endif

  palette_converter #(.INDEX_W(3), .CHAN_W(8), .NUM_CHAN(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .colour(colour),
`ifdef PALETTE_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .rgb(rgb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  palette_converter #(.INDEX_W(4), .CHAN_W(4), .NUM_CHAN(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid4), .in_ready(in_ready4), .colour(colour4),
`ifdef PALETTE_BRIGHTNESS_EN
    .brightness(brightness4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .rgb(rgb4),
    .wr_en(1'b0), .wr_addr(4'h0), .wr_data(12'h000)
  );

  always #5 clk = ~clk;

  logic [23:0] model [8];
  logic [23:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] held_rgb;
  logic        held_valid;

  task automatic load_defaults();
    model[0] = 24'h000000; model[1] = 24'h0000FF;
    model[2] = 24'h00FF00; model[3] = 24'h00FFFF;
    model[4] = 24'hFF0000; model[5] = 24'hFF00FF;
    model[6] = 24'hFFFF00; model[7] = 24'hFFFFFF;
  endtask

  function automatic logic [23:0] scale(input logic [23:0] v);
`ifdef PALETTE_BRIGHTNESS_EN
    logic [23:0] r;
    int          b;
    b = int'(brightness) + 1;
    for (int ch = 0; ch < 3; ch++) begin
      r[ch*8 +: 8] = 8'((int'(v[ch*8 +: 8]) * b) >> 8);
    end
    return r;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then step past the edge.
  task automatic cyc();
    logic [23:0] e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      e = (wr_en && wr_addr == colour) ? wr_data : model[colour];
      exp_q.push_back(scale(e));
    end
    if (out_valid && out_ready && enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {40'h0, rgb}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("stream_rgb", {40'h0, rgb}, {40'h0, e});
      end
    end
    if (wr_en) model[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) cyc();
    check("drain_empty", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic read4(input logic [3:0] idx, input logic [11:0] exp, input string tag);
    int n;
    colour4 = idx;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 1;
    while (!out_valid4 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, {63'h0, out_valid4}, 64'h1);
    check(tag, {52'h0, rgb4}, {52'h0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    load_defaults();
    // Reset state
    #12;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_rgb", {40'h0, rgb}, 64'h0);
    check("rst_in_ready_en1", {63'h0, in_ready}, 64'h1);
    enable = 1'b0; #1;
    check("rst_in_ready_en0", {63'h0, in_ready}, 64'h0);
    enable = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Stream indices 0..7
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      colour = 3'(i);
      cyc();
      if (i == 0) check("first_latency", {63'h0, out_valid}, (LAT == 1) ? 64'h1 : 64'h0);
    end
    drain();
    check("stream_last_hold", {40'h0, rgb}, {40'h0, scale(24'hFFFFFF)});

    // Write-through collision, then a following read of the same index
    in_valid = 1'b1; colour = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'h123456;
    cyc();
    wr_en = 1'b0;
    cyc();
    drain();
    check("collision_followup", {40'h0, rgb}, {40'h0, scale(24'h123456)});

    // Back-to-back writes, last wins
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h111111; cyc();
    wr_data = 24'h222222; cyc();
    wr_en = 1'b0;
    in_valid = 1'b1; colour = 3'd2; cyc();
    drain();
    check("last_write_wins", {40'h0, rgb}, {40'h0, scale(24'h222222)});

    // Backpressure: four stalled cycles with a request pending
    in_valid = 1'b1; colour = 3'd1; cyc();
    colour = 3'd3; cyc();
    out_ready = 1'b0; colour = 3'd4; cyc();
    held_rgb = rgb;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_in_ready", {63'h0, in_ready}, 64'h0);
      check("stall_out_valid", {63'h0, out_valid}, 64'h1);
      check("stall_rgb_stable", {40'h0, rgb}, {40'h0, held_rgb});
    end
    drain();

    // Enable low freezes the pipeline but writes still land
    in_valid = 1'b1; colour = 3'd6; cyc();
    in_valid = 1'b0; enable = 1'b0;
    held_rgb = rgb; held_valid = out_valid;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hABCDEF;
    for (int i = 0; i < 2; i++) begin
      cyc();
      wr_en = 1'b0;
      check("freeze_in_ready", {63'h0, in_ready}, 64'h0);
      check("freeze_out_valid", {63'h0, out_valid}, {63'h0, held_valid});
      check("freeze_rgb", {40'h0, rgb}, {40'h0, held_rgb});
    end
    enable = 1'b1;
    in_valid = 1'b1; colour = 3'd0; cyc();
    drain();
    check("write_while_disabled", {40'h0, rgb}, {40'h0, scale(24'hABCDEF)});

    // Asynchronous reset mid-stream
    in_valid = 1'b1; colour = 3'd5; cyc(); cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_rgb", {40'h0, rgb}, 64'h0);
    in_valid = 1'b0;
    exp_q.delete();
    load_defaults();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; colour = 3'd5; cyc();
    drain();
    check("post_rst_idx5", {40'h0, rgb}, {40'h0, scale(24'hFF00FF)});

    // 4-bit index, 4-bit channel instance
    read4(4'd12, 12'h000, "w4_idx12");
    read4(4'd7, 12'hFFF, "w4_idx7");
    read4(4'd4, 12'hF00, "w4_idx4");

`ifdef PALETTE_BRIGHTNESS_EN
    brightness = 8'h7F;
    in_valid = 1'b1; colour = 3'd7; cyc();
    drain();
    check("bright_7f", {40'h0, rgb}, 64'h7F7F7F);
    brightness = 8'hFF;
    in_valid = 1'b1; colour = 3'd4; cyc();
    drain();
    check("bright_ff_identity", {40'h0, rgb}, 64'hFF0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_converter.md
# palette_converter

Parametrised, writable colour-index-to-RGB lookup with a valid/ready streaming interface. It succeeds the fixed 8-entry read-only colour converter. It holds a register-based palette of `2**INDEX_W` entries, each `NUM_CHAN × CHAN_W` bits, and reset-loads the standard 8-colour table. It sits between the pixel-index generator and the display/output formatter, and supports run-time palette rewrites.

## Interface
Parameters:
- `INDEX_W`, default 3: index width. Depth is `DEPTH = 2**INDEX_W`. Legal range is 3..8.
- `CHAN_W`, default 8: bits per colour channel. Must be ≥ 1.
- `NUM_CHAN`, default 3: channels per entry. Channel `NUM_CHAN-1` is MS (R for RGB).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: global run gate. When low, the read pipeline is frozen and writes are still accepted.
- `in_valid` in 1: index request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `colour` in `INDEX_W`: palette index.
- `out_valid` out 1: `rgb` valid.
- `out_ready` in 1: downstream accepts `rgb`.
- `rgb` out `NUM_CHAN*CHAN_W`: looked-up colour.
- `wr_en` in 1: palette write strobe. Single cycle, always accepted.
- `wr_addr` in `INDEX_W`: write index.
- `wr_data` in `NUM_CHAN*CHAN_W`: write value.

## Operation
- Palette reset contents, for entries 0..7: black, blue, green, cyan, red, magenta, yellow, white.
  - Bit 0 of the index drives the B channel, bit 1 drives G, bit 2 drives R.
  - Each channel is all-ones when its bit is set, all-zeros otherwise. Entry 4 at defaults is 0xFF0000.
  - With `NUM_CHAN > 3`, extra channels reset to 0.
  - Entries ≥ 8 reset to 0.
- Pipeline advance condition: `adv = enable & (!out_valid | out_ready)`.
- Ready output: `in_ready = adv`, purely combinational. There is no path from `in_valid` to `in_ready`.
- Accepted request: on `in_valid & adv`, the output register loads `palette[colour]` and `out_valid` is set.
- `adv` with `!in_valid`: `out_valid` clears on that edge. `rgb` holds its last value.
- Backpressure: while `out_valid & !out_ready`, `rgb` and `out_valid` are held stable, and no new request is accepted.
- Writes: `wr_en` updates `palette[wr_addr]` at the clock edge. Writes are independent of `enable` and of the handshake.
- Read/write collision: a read accepted in the same cycle as a write to the same index returns `wr_data` (write-through).
- Already-held output: an `rgb` value already in the output register is not altered by later writes.
- Multiple writes: back-to-back writes to the same index are allowed. The last write wins.
- Reset: asserting `rst_n` low mid-stream immediately clears `out_valid` and `rgb` to 0 and restores the palette defaults. Any in-flight data is discarded.

## Timing
- Reset values: `out_valid` = 0, `rgb` = 0. `in_ready` is 0 while `enable` = 0; otherwise it follows `adv`.
- Read latency: 1 cycle from acceptance to `out_valid`, or 2 cycles with `PALETTE_BRIGHTNESS_EN`.
- Throughput: 1 lookup per cycle while `out_ready` = 1.
- Write-to-read visibility: a write at edge N is visible to a read accepted at edge N, via write-through.

## Configuration
- Macro `PALETTE_BRIGHTNESS_EN` absent: behaviour is as above.
- Macro `PALETTE_BRIGHTNESS_EN` defined:
  - Adds input `brightness` [`CHAN_W`-1:0], sampled together with `colour` on acceptance.
  - Each channel becomes `(chan * (brightness + 1)) >> CHAN_W`. The product is computed at full `2*CHAN_W+1` width and truncated; there is no rounding.
    - `brightness` = all-ones gives identity.
    - `brightness` = 0 with `chan` = 0xFF gives 0x00.
  - This adds a second pipeline stage. Both stages advance together on `adv`, with one `out_valid` per stage tracked internally.
  - `in_ready` is unchanged: it is still gated only by the output-stage stall.
  - Latency becomes 2, throughput is unchanged, and stage-1 valid resets to 0.

## Structure
- Shared package `palette_pkg` holds:
  - `DEFAULT_PALETTE`, the 8-entry base-colour table as per-bit channel masks.
  - The channel index constants `CH_R = 2`, `CH_G = 1`, `CH_B = 0`.
  - A function `default_entry(idx, CHAN_W, NUM_CHAN)` that builds the reset value of an entry.
- Sub-module `palette_ram` contains the register array, the asynchronous reset load, the single write port, and a combinational read with write-through bypass.
- `palette_converter` contains the handshake, the output register(s), and the optional brightness stage.

## Test plan
- Reset, then stream indices 0..7 with `out_ready` = 1 → `rgb` sequence is 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF, one per cycle starting 1 cycle after the first acceptance.
- Write `wr_addr` = 5, `wr_data` = 0x123456 in the same cycle as a read of index 5 → that read returns 0x123456. A read of index 5 from the following cycle also returns 0x123456.
- Hold `out_ready` = 0 for 4 cycles with `in_valid` = 1 → `in_ready` = 0, `rgb` stays stable, and no requests are lost or duplicated after release. Toggle `enable` low mid-stream → pipeline freezes and `wr_en` still lands.
- Assert `rst_n` low mid-stream after palette writes → `out_valid` and `rgb` are 0 immediately. After release, index 5 reads FF00FF.
- With `INDEX_W` = 4, `CHAN_W` = 4: index 12 reads 0x000 after reset, and index 7 reads 0xFFF.
- With `PALETTE_BRIGHTNESS_EN` and `brightness` = 0x7F, index 7 → `rgb` = 0x7F7F7F after 2 cycles.
- With `PALETTE_BRIGHTNESS_EN` and `brightness` = 0xFF → `rgb` equals the unscaled entry.
